mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single-port program/data memory between the CPU datapath (control-unit
//  memory_read/memory_write traffic) and the program-loader/debug port. Serialises
//  accesses with a req/ack handshake, sequences the memory access for MEM_LAT cycles,
//  returns read data, and raises cpu_stall so the sequence counter freezes the T[] step.
// PARAMETERS
//  AW           8  address width
//  DW           8  data width
//  MEM_LAT      1  cycles mem_en is held before mem_rdata is valid (>=1)
//  MAX_BURST    4  consecutive high-priority grants allowed while the other side waits (>=1)
//  LDR_PRIORITY 1  1: loader is high priority; 0: CPU is high priority
// PORTS
//  clk        in  1   clock, rising edge
//  reset      in  1   asynchronous, active-high
//  cpu_req    in  1   CPU access request; held until cpu_ack
//  cpu_we     in  1   1 = write, 0 = read
//  cpu_addr   in  AW  CPU address
//  cpu_wdata  in  DW  CPU write data
//  cpu_rdata  out DW  CPU read data, valid while cpu_ack=1, held until the next CPU read
//  cpu_ack    out 1   one-cycle completion pulse
//  cpu_stall  out 1   cpu_req & ~cpu_ack (combinational)
//  ldr_req/ldr_we/ldr_addr/ldr_wdata/ldr_rdata/ldr_ack  same as cpu_*, loader side
//  mem_en     out 1   memory access enable
//  mem_we     out 1   memory write enable
//  mem_addr   out AW  memory address
//  mem_wdata  out DW  memory write data
//  mem_rdata  in  DW  memory read data, valid on the last ACCESS cycle
//  bus_owner  out 2   00 none, 01 CPU, 10 loader; owner during ACCESS/RESP
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; rdata registers 0; latency and burst counters 0.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE: if any req, pick the winner. Latch owner, we, addr and wdata into registers.
//     Load lat_cnt=MEM_LAT and go to ACCESS. With no req, stay in IDLE; mem_* = 0.
//   ACCESS: mem_en=1; mem_we/addr/wdata come from the latched registers and are stable
//     for all MEM_LAT cycles. lat_cnt decrements each cycle. When lat_cnt==1: for a read,
//     capture mem_rdata into the owner's rdata register; then go to RESP.
//   RESP: owner's ack=1 for exactly one cycle; mem_en=0; go to IDLE.
//  Latency: req first seen in IDLE at cycle 0 -> mem_en in cycles 1..MEM_LAT -> ack in
//   cycle MEM_LAT+1. The earliest next grant is evaluated in cycle MEM_LAT+2.
//  Handshake: requester holds req/we/addr/wdata stable until ack and drops req in the
//   cycle after ack. Requests are sampled only in IDLE. A req dropped mid-access does not
//   abort the access; ack is still issued and the other rdata register is untouched.
//  Arbitration, evaluated in IDLE:
//   - Only one side requesting: that side wins.
//   - Both requesting: the high-priority side wins unless burst_cnt==MAX_BURST, in which
//     case the low-priority side wins.
//   - burst_cnt increments when the high side wins while the low side is requesting.
//     It saturates at MAX_BURST and clears on any low-side grant or any IDLE cycle where
//     the low side is not requesting.
//  Writes ignore mem_rdata; the rdata register keeps its previous value.
//  Reset mid-access: immediate return to IDLE, mem_en drops asynchronously, no ack issued,
//   and the requester must re-request.
//  No combinational path from req to mem_*; cpu_stall is the only combinational output.
// STRUCTURE
//  Shared package/header arb_pkg: owner codes (OWN_NONE/OWN_CPU/OWN_LDR) and state
//   encoding (ST_IDLE/ST_ACCESS/ST_RESP); the control unit and top level reuse the owner
//   codes.
//  One natural sub-module, arb_fair_pick: combinational winner select plus the burst_cnt
//   register; inputs cpu_req, ldr_req, arbitrate; outputs grant_cpu, grant_ldr.
//  Everything else (FSM, latch registers, lat_cnt, rdata registers) stays in this module.
// TESTING
//  1 Reset then CPU read, MEM_LAT=1, addr 0x10, memory holds 0xA5 -> mem_en in cycle 1 only;
//    cpu_ack in cycle 2 with cpu_rdata=0xA5; cpu_stall=1 in cycles 0-1 and 0 in cycle 2.
//  2 Loader write addr 0x3F data 0x5C, MEM_LAT=3 -> mem_en=mem_we=1 and addr/data stable in
//    cycles 1-3; ldr_ack in cycle 4; a later CPU read of 0x3F returns 0x5C.
//  3 cpu_req and ldr_req both held continuously, LDR_PRIORITY=1, MAX_BURST=4 ->
//    grant order L,L,L,L,C,L,L,L,L,C; bus_owner matches each grant.
//  4 Simultaneous req with only cpu_req set after a loader-only run -> CPU wins at once;
//    burst_cnt is 0 at the next contention.
//  5 reset asserted in the 2nd ACCESS cycle of a CPU read (MEM_LAT=3) -> mem_en=0 the same
//    cycle; no cpu_ack; cpu_rdata=0; a re-request completes normally.
//  6 CPU drops cpu_req in cycle 1 of a read -> access completes; cpu_ack pulses once;
//    ldr_rdata is unchanged.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared codes for the memory bus arbiter: bus owner encoding and FSM states.
package arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_LDR  = 2'b10
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic owner_e pick_owner(input logic grant_ldr);
    return grant_ldr ? OWN_LDR : OWN_CPU;
  endfunction

endpackage

// File: rtl/arb_fair_pick.sv
// Winner select for the two requesters, with a burst limit so the
// low-priority side gets a slot after MAX_BURST back-to-back losses.
module arb_fair_pick #(
  parameter int MAX_BURST    = 4,
  parameter bit LDR_PRIORITY = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic arbitrate,
  output logic grant_cpu,
  output logic grant_ldr
);

  localparam int BW = $clog2(MAX_BURST + 1);

  logic [BW-1:0] burst_cnt;
  logic          hi_req, lo_req, grant_hi, grant_lo, at_limit;

  assign hi_req   = LDR_PRIORITY ? ldr_req : cpu_req;
  assign lo_req   = LDR_PRIORITY ? cpu_req : ldr_req;
  assign at_limit = (burst_cnt == BW'(MAX_BURST));

  // Low side only overrides when it is actually waiting and the budget is spent.
  assign grant_hi = arbitrate & hi_req & ~(lo_req & at_limit);
  assign grant_lo = arbitrate & lo_req & ~grant_hi;

  assign grant_cpu = LDR_PRIORITY ? grant_lo : grant_hi;
  assign grant_ldr = LDR_PRIORITY ? grant_hi : grant_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (arbitrate) begin
      if (grant_lo || !lo_req)
        burst_cnt <= '0;
      else if (grant_hi && !at_limit)
        burst_cnt <= burst_cnt + BW'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory between the CPU and the loader/debug port:
// arbitrate in IDLE, drive the memory for MEM_LAT cycles, then pulse ack.
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int MEM_LAT      = 1,
  parameter int MAX_BURST    = 4,
  parameter bit LDR_PRIORITY = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  output logic          ldr_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    bus_owner
);

  localparam int LW = $clog2(MEM_LAT + 1);

  state_e        state, state_nx;
  owner_e        own_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, cpu_rdata_q, ldr_rdata_q;
  logic [LW-1:0] lat_cnt;
  logic          grant_cpu, grant_ldr, arbitrate, last_beat;

  assign arbitrate = (state == ST_IDLE);
  assign last_beat = (lat_cnt == LW'(1));

  arb_fair_pick #(
    .MAX_BURST    (MAX_BURST),
    .LDR_PRIORITY (LDR_PRIORITY)
  ) u_pick (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .ldr_req   (ldr_req),
    .arbitrate (arbitrate),
    .grant_cpu (grant_cpu),
    .grant_ldr (grant_ldr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Memory outputs come only from latched registers, never from the req inputs.
  always_comb begin
    state_nx  = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    bus_owner = OWN_NONE;
    cpu_ack   = 1'b0;
    ldr_ack   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_cpu || grant_ldr) state_nx = ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        bus_owner = own_q;
        if (last_beat) state_nx = ST_RESP;
      end
      ST_RESP: begin
        bus_owner = own_q;
        cpu_ack   = (own_q == OWN_CPU);
        ldr_ack   = (own_q == OWN_LDR);
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_q       <= OWN_NONE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_cnt     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_cpu || grant_ldr) begin
            own_q   <= pick_owner(grant_ldr);
            we_q    <= grant_ldr ? ldr_we    : cpu_we;
            addr_q  <= grant_ldr ? ldr_addr  : cpu_addr;
            wdata_q <= grant_ldr ? ldr_wdata : cpu_wdata;
            lat_cnt <= LW'(MEM_LAT);
          end
        end
        ST_ACCESS: begin
          lat_cnt <= lat_cnt - LW'(1);
          if (last_beat && !we_q) begin
            if (own_q == OWN_CPU) cpu_rdata_q <= mem_rdata;
            else                  ldr_rdata_q <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign ldr_stall = ldr_req & ~ldr_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (MEM_LAT 1 and 3), each with its own
// memory, directed scenarios plus random traffic against a timeline model.
module tb_mem_bus_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int MAXB = 4;

  logic            clk;
  logic [1:0]      rst;
  logic [1:0]      cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [1:0][7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [1:0]      ldr_req, ldr_we, ldr_ack, ldr_stall;
  logic [1:0][7:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic [1:0]      mem_en, mem_we;
  logic [1:0][7:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0][1:0] bus_owner;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hB5;
    always @(posedge clk) if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
    assign mem_rdata[g] = mem[mem_addr[g]];

    mem_bus_arbiter #(
      .AW(8), .DW(8), .MEM_LAT(g == 0 ? LAT0 : LAT1), .MAX_BURST(MAXB), .LDR_PRIORITY(1'b1)
    ) u_dut (
      .clk(clk), .reset(rst[g]),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_rdata(cpu_rdata[g]), .cpu_ack(cpu_ack[g]), .cpu_stall(cpu_stall[g]),
      .ldr_req(ldr_req[g]), .ldr_we(ldr_we[g]), .ldr_addr(ldr_addr[g]), .ldr_wdata(ldr_wdata[g]),
      .ldr_rdata(ldr_rdata[g]), .ldr_ack(ldr_ack[g]), .ldr_stall(ldr_stall[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .bus_owner(bus_owner[g])
    );
  end

  function automatic int lat_of(input int d);
    return d == 0 ? LAT0 : LAT1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request/ack handshake; ack_at is the cycle index of ack, -1 on timeout.
  task automatic do_xact(input int d, input bit ldr, input bit we, input logic [7:0] a,
                         input logic [7:0] wd, output int ack_at, output logic [7:0] rd);
    ack_at = -1;
    rd     = '0;
    tick();
    if (ldr) begin ldr_req[d] = 1; ldr_we[d] = we; ldr_addr[d] = a; ldr_wdata[d] = wd; end
    else     begin cpu_req[d] = 1; cpu_we[d] = we; cpu_addr[d] = a; cpu_wdata[d] = wd; end
    for (int c = 0; c < 20 && ack_at < 0; c++) begin
      if (c > 0) tick();
      #1;
      if (ldr ? ldr_ack[d] : cpu_ack[d]) begin
        ack_at = c;
        rd     = ldr ? ldr_rdata[d] : cpu_rdata[d];
      end
    end
    tick();
    cpu_req[d] = 0;
    ldr_req[d] = 0;
  endtask

  task automatic test_reset();
    rst = 2'b11;
    cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = '0; ldr_we = '0; ldr_addr = '0; ldr_wdata = '0;
    tick(); tick(); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({cpu_ack[d], ldr_ack[d], cpu_stall[d], ldr_stall[d], mem_en[d], mem_we[d], mem_addr[d],
           mem_wdata[d], bus_owner[d], cpu_rdata[d], ldr_rdata[d]} !== '0)
        begin errors++; $display("FAIL reset_outputs d=%0d: got en=%b own=%b crd=%h lrd=%h ack=%b%b, want all 0",
          d, mem_en[d], bus_owner[d], cpu_rdata[d], ldr_rdata[d], cpu_ack[d], ldr_ack[d]); end
    end
    tick();
    rst = 2'b00;
  endtask

  task automatic test_cpu_read();
    int L = lat_of(0);
    logic [16:0] got, exp;
    for (int c = 0; c <= L + 2; c++) begin
      tick();
      if (c == 0) begin cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 8'h10; end
      if (c == L + 2) cpu_req[0] = 0;
      #1;
      begin
        bit en  = (c >= 1 && c <= L);
        bit ack = (c == L + 1);
        exp = {en, ack, (c <= L + 1) && !ack, (en || ack) ? 2'b01 : 2'b00,
               en ? 8'h10 : 8'h00, 4'd0};
        got = {mem_en[0], cpu_ack[0], cpu_stall[0], bus_owner[0],
               mem_en[0] ? mem_addr[0] : 8'h00, 4'd0};
        checks++;
        if (got !== exp) begin errors++;
          $display("FAIL cpu_read_timing c=%0d: got en/ack/stall/own/addr=%h, want %h", c, got, exp); end
        if (c >= L + 1) begin
          checks++;
          if (cpu_rdata[0] !== 8'hA5) begin errors++;
            $display("FAIL cpu_read_data c=%0d: got %h want a5", c, cpu_rdata[0]); end
        end
      end
    end
  endtask

  task automatic test_ldr_write();
    int L = lat_of(1);
    int at;
    logic [7:0] rd;
    logic [20:0] got, exp;
    for (int c = 0; c <= L + 2; c++) begin
      tick();
      if (c == 0) begin ldr_req[1] = 1; ldr_we[1] = 1; ldr_addr[1] = 8'h3F; ldr_wdata[1] = 8'h5C; end
      if (c == L + 2) ldr_req[1] = 0;
      #1;
      begin
        bit en  = (c >= 1 && c <= L);
        bit ack = (c == L + 1);
        exp = {en, ack, (en || ack) ? 2'b10 : 2'b00, en ? {1'b1, 8'h3F, 8'h5C} : 17'd0};
        got = {mem_en[1], ldr_ack[1], bus_owner[1],
               mem_en[1] ? {mem_we[1], mem_addr[1], mem_wdata[1]} : 17'd0};
        checks++;
        if (got !== exp) begin errors++;
          $display("FAIL ldr_write_cycle c=%0d: got %h want %h", c, got, exp); end
      end
    end
    checks++;
    if (ldr_rdata[1] !== 8'h00) begin errors++;
      $display("FAIL ldr_write_rdata_kept: got %h want 00", ldr_rdata[1]); end
    do_xact(1, 0, 0, 8'h3F, 8'h00, at, rd);
    checks++;
    if (at !== L + 1 || rd !== 8'h5C) begin errors++;
      $display("FAIL readback_3f: got ack_at=%0d data=%h want ack_at=%0d data=5c", at, rd, L + 1); end
  endtask

  task automatic test_priority_burst();
    string got_s = "";
    string exp_s = "";
    int n = 0;
    int burst = 0;
    for (int i = 0; i < 10; i++) begin
      if (burst == MAXB) begin exp_s = {exp_s, "C"}; burst = 0; end
      else begin exp_s = {exp_s, "L"}; burst++; end
    end
    tick();
    cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 8'h01;
    ldr_req[0] = 1; ldr_we[0] = 0; ldr_addr[0] = 8'h02;
    for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
      if (cyc > 0) tick();
      #1;
      if (cpu_ack[0] || ldr_ack[0]) begin
        logic [1:0] want_own = cpu_ack[0] ? 2'b01 : 2'b10;
        got_s = {got_s, cpu_ack[0] ? "C" : "L"};
        checks++;
        if (bus_owner[0] !== want_own || (cpu_ack[0] && ldr_ack[0])) begin errors++;
          $display("FAIL burst_owner grant %0d: got owner=%b acks=%b%b want owner=%b single ack",
            n, bus_owner[0], cpu_ack[0], ldr_ack[0], want_own); end
        n++;
      end
    end
    tick();
    cpu_req[0] = 0; ldr_req[0] = 0;
    checks++;
    if (got_s != exp_s) begin errors++;
      $display("FAIL burst_order: got %s want %s", got_s, exp_s); end
  endtask

  task automatic test_single_req();
    int L = lat_of(0);
    int at, nl;
    logic [7:0] rd;
    bit seen_c;
    tick();
    cpu_req[0] = 1; ldr_req[0] = 1;
    nl = 0;
    for (int cyc = 0; cyc < 50 && nl < 2; cyc++) begin
      tick(); #1;
      if (ldr_ack[0]) nl++;
    end
    tick();
    cpu_req[0] = 0; ldr_req[0] = 0;
    for (int i = 0; i < 2; i++) begin
      do_xact(0, 1, 0, 8'h08 + 8'(i), 8'h00, at, rd);
      checks++;
      if (at !== L + 1) begin errors++;
        $display("FAIL ldr_only_latency %0d: got %0d want %0d", i, at, L + 1); end
    end
    do_xact(0, 0, 0, 8'h05, 8'h00, at, rd);
    checks++;
    if (at !== L + 1 || rd !== 8'hB0) begin errors++;
      $display("FAIL cpu_only_win: got ack_at=%0d data=%h want ack_at=%0d data=b0", at, rd, L + 1); end
    tick();
    cpu_req[0] = 1; ldr_req[0] = 1;
    nl = 0; seen_c = 0;
    for (int cyc = 0; cyc < 100 && !seen_c; cyc++) begin
      tick(); #1;
      if (cpu_ack[0]) seen_c = 1;
      else if (ldr_ack[0]) nl++;
    end
    tick();
    cpu_req[0] = 0; ldr_req[0] = 0;
    checks++;
    if (!seen_c || nl != MAXB) begin errors++;
      $display("FAIL burst_cleared: got %0d loader grants before cpu (cpu seen=%0d) want %0d",
        nl, seen_c, MAXB); end
  endtask

  task automatic test_reset_mid();
    int L = lat_of(1);
    int at;
    logic [7:0] rd;
    bit acked = 0;
    tick();
    cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 8'h20;
    tick();
    tick(); #1;
    checks++;
    if (mem_en[1] !== 1'b1) begin errors++;
      $display("FAIL reset_mid_pre: got mem_en=%b want 1", mem_en[1]); end
    rst[1] = 1;
    #1;
    checks++;
    if ({mem_en[1], bus_owner[1], cpu_ack[1], cpu_rdata[1]} !== '0) begin errors++;
      $display("FAIL reset_mid_async: got en=%b own=%b ack=%b rdata=%h want all 0",
        mem_en[1], bus_owner[1], cpu_ack[1], cpu_rdata[1]); end
    cpu_req[1] = 0;
    tick();
    rst[1] = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      if (cpu_ack[1]) acked = 1;
    end
    checks++;
    if (acked || cpu_rdata[1] !== 8'h00) begin errors++;
      $display("FAIL reset_mid_no_ack: got ack_seen=%0d rdata=%h want 0 and 00", acked, cpu_rdata[1]); end
    do_xact(1, 0, 0, 8'h20, 8'h00, at, rd);
    checks++;
    if (at !== L + 1 || rd !== 8'h95) begin errors++;
      $display("FAIL reset_mid_rereq: got ack_at=%0d data=%h want ack_at=%0d data=95", at, rd, L + 1); end
  endtask

  task automatic test_drop_req();
    int L = lat_of(1);
    int at, n = 0, ack_c = -1;
    logic [7:0] rd, crd = '0;
    do_xact(1, 1, 0, 8'h41, 8'h00, at, rd);
    checks++;
    if (at !== L + 1 || rd !== 8'hF4) begin errors++;
      $display("FAIL drop_pre_ldr_read: got ack_at=%0d data=%h want ack_at=%0d data=f4", at, rd, L + 1); end
    for (int c = 0; c <= 8; c++) begin
      tick();
      if (c == 0) begin cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 8'h42; end
      if (c == 1) cpu_req[1] = 0;
      #1;
      if (cpu_ack[1]) begin n++; ack_c = c; crd = cpu_rdata[1]; end
    end
    checks++;
    if (n != 1 || ack_c != L + 1 || crd !== 8'hF7 || ldr_rdata[1] !== 8'hF4) begin errors++;
      $display("FAIL drop_req: got acks=%0d at=%0d crd=%h lrd=%h want 1 at %0d crd=f7 lrd=f4",
        n, ack_c, crd, ldr_rdata[1], L + 1); end
  endtask

  // Random traffic from two agents; expectations come from a grant timeline:
  // a grant at cycle g means access in g+1..g+L, ack in g+L+1, free again at g+L+2.
  task automatic test_random(input int d, input int ncyc);
    int L = lat_of(d);
    bit         areq [2], awe [2], acked_prev [2];
    logic [2:0] aad [2];
    logic [7:0] awd [2], erd [2], rm [8];
    int         agap [2];
    int free_at = 0, gcyc = -1000, burst = 0, shown = 0;
    bit gside = 0, gwe = 0, win, en, ack;
    logic [2:0] gad = '0;
    logic [7:0] gwd = '0;
    logic [39:0] got, exp;
    for (int i = 0; i < 8; i++) rm[i] = (8'h80 | 8'(i)) ^ 8'hB5;
    for (int s = 0; s < 2; s++) begin
      areq[s] = 0; acked_prev[s] = 0; agap[s] = 0; erd[s] = '0; awe[s] = 0; aad[s] = '0; awd[s] = '0;
    end
    tick(); rst[d] = 1;
    tick(); rst[d] = 0;
    for (int k = 0; k < ncyc; k++) begin
      tick();
      for (int s = 0; s < 2; s++) begin
        if (acked_prev[s]) begin areq[s] = 0; agap[s] = $urandom_range(0, 3); end
        if (!areq[s]) begin
          if (agap[s] == 0) begin
            areq[s] = 1;
            awe[s]  = ($urandom_range(0, 2) == 0);
            aad[s]  = 3'($urandom_range(0, 7));
            awd[s]  = 8'($urandom);
          end else agap[s]--;
        end
      end
      cpu_req[d] = areq[0]; cpu_we[d] = awe[0]; cpu_addr[d] = {5'b10000, aad[0]}; cpu_wdata[d] = awd[0];
      ldr_req[d] = areq[1]; ldr_we[d] = awe[1]; ldr_addr[d] = {5'b10000, aad[1]}; ldr_wdata[d] = awd[1];
      if (k >= free_at) begin
        if (areq[0] || areq[1]) begin
          win = areq[1] && !(areq[0] && burst == MAXB);
          if (win && areq[0]) burst++;
          else burst = 0;
          gcyc = k; gside = win; gwe = awe[win]; gad = aad[win]; gwd = awd[win];
          free_at = k + L + 2;
        end else burst = 0;
      end
      en  = (k > gcyc && k <= gcyc + L);
      ack = (k == gcyc + L + 1);
      if (ack) begin
        if (gwe) rm[gad] = gwd;
        else     erd[gside] = rm[gad];
      end
      acked_prev[0] = ack && !gside;
      acked_prev[1] = ack && gside;
      exp = {ack && !gside, ack && gside, en, (en || ack) ? (gside ? 2'b10 : 2'b01) : 2'b00,
             areq[0] && !(ack && !gside), areq[1] && !(ack && gside), erd[0], erd[1],
             en ? {gwe, 5'b10000, gad, gwe ? gwd : 8'h00} : 17'd0};
      #1;
      got = {cpu_ack[d], ldr_ack[d], mem_en[d], bus_owner[d], cpu_stall[d], ldr_stall[d],
             cpu_rdata[d], ldr_rdata[d],
             mem_en[d] ? {mem_we[d], mem_addr[d], mem_we[d] ? mem_wdata[d] : 8'h00} : 17'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random d=%0d cycle %0d: got %h want %h", d, k, got, exp);
        end
      end
    end
    tick();
    cpu_req[d] = 0; ldr_req[d] = 0;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_ldr_write();
    test_priority_burst();
    test_single_req();
    test_reset_mid();
    test_drop_req();
    test_random(0, 300);
    test_random(1, 300);
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
